// File: rtl/alu.sv
// 8-bit datapath ALU: combinational result and status flags, plus one
// registered shift/carry flag for chaining multi-byte operations.
//
// Ports:
//   Clk      in   clock; SC_Q updates on the rising edge
//   Reset_n  in   asynchronous active-low reset; clears SC_Q only
//   DatA     in   operand A
//   DatB     in   operand B
//   ALUop    in   operation select (ADD LSH AND OR SUB RSH CMP XOR)
//   SC_IN    in   shift-in bit used by LSH
//   FlagEn   in   when high, SC_Q captures SC_OUT on the rising edge
//   Rslt     out  operation result (combinational)
//   Zero     out  Rslt is all zeros (combinational)
//   Par      out  odd parity of Rslt (combinational)
//   SC_OUT   out  carry / borrow / shifted-out bit of the current op (combinational)
//   SC_Q     out  registered SC_OUT
module alu #(
  parameter int unsigned W = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [W-1:0] DatA,
  input  logic [W-1:0] DatB,
  input  logic [2:0]   ALUop,
  input  logic         SC_IN,
  input  logic         FlagEn,
  output logic [W-1:0] Rslt,
  output logic         Zero,
  output logic         Par,
  output logic         SC_OUT,
  output logic         SC_Q
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_LSH = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_RSH = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam int unsigned WE = W + 1;

  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;
  logic         a_gt_b;
  logic         a_ne_b;
  logic [W-1:0] rslt_c;
  logic         sc_out_c;
  logic         sc_d;
  logic         sc_q;

  // Extended adders: bit W is the carry out of ADD and the borrow of SUB.
  assign sum_ext  = WE'(DatA) + WE'(DatB);
  assign diff_ext = WE'(DatA) - WE'(DatB);
  assign a_gt_b   = (DatA > DatB);
  assign a_ne_b   = (DatA != DatB);

  // Result and carry/shift-out select.
  always_comb begin
    rslt_c   = '0;
    sc_out_c = 1'b0;
    unique case (ALUop)
      OP_ADD: begin
        rslt_c   = sum_ext[W-1:0];
        sc_out_c = sum_ext[W];
      end
      OP_LSH: begin
        rslt_c   = {DatA[W-2:0], SC_IN};
        sc_out_c = DatA[W-1];
      end
      OP_AND: rslt_c = DatA & DatB;
      OP_OR:  rslt_c = DatA | DatB;
      OP_SUB: begin
        rslt_c   = diff_ext[W-1:0];
        sc_out_c = diff_ext[W];
      end
      OP_RSH: begin
        rslt_c   = {1'b0, DatA[W-1:1]};
        sc_out_c = DatA[0];
      end
      OP_CMP: rslt_c = {{(W-2){1'b0}}, a_gt_b, a_ne_b};
      OP_XOR: rslt_c = DatA ^ DatB;
      default: begin
        rslt_c   = '0;
        sc_out_c = 1'b0;
      end
    endcase
  end

  assign Rslt   = rslt_c;
  assign Zero   = (rslt_c == '0);
  assign Par    = ^rslt_c;
  assign SC_OUT = sc_out_c;

  // Flag register: load on FlagEn, otherwise hold.
  assign sc_d = FlagEn ? sc_out_c : sc_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sc_q <= 1'b0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign SC_Q = sc_q;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: table of combinational vectors followed by
// hand-written sequences for the SC_Q flag register and reset behaviour.
module tb_alu;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       sc_in;
    logic [7:0] rslt;
    logic       zero;
    logic       par;
    logic       sc_out;
  } vec_t;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] LSH = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] SUB = 3'b100;
  localparam logic [2:0] RSH = 3'b101;
  localparam logic [2:0] CMP = 3'b110;
  localparam logic [2:0] XOR = 3'b111;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] DatA;
  logic [7:0] DatB;
  logic [2:0] ALUop;
  logic       SC_IN;
  logic       FlagEn;
  logic [7:0] Rslt;
  logic       Zero;
  logic       Par;
  logic       SC_OUT;
  logic       SC_Q;

  int n_applied;
  int n_miss;
  vec_t vecs[$];

  alu #(.W(8)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .DatA   (DatA),
    .DatB   (DatB),
    .ALUop  (ALUop),
    .SC_IN  (SC_IN),
    .FlagEn (FlagEn),
    .Rslt   (Rslt),
    .Zero   (Zero),
    .Par    (Par),
    .SC_OUT (SC_OUT),
    .SC_Q   (SC_Q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic sc_in, input logic [7:0] rslt, input logic zero,
                              input logic par, input logic sc_out);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sc_in = sc_in;
    v.rslt = rslt; v.zero = zero; v.par = par; v.sc_out = sc_out;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  initial begin
    n_applied = 0;
    n_miss    = 0;
    Reset_n   = 1'b0;
    DatA      = 8'h00;
    DatB      = 8'h00;
    ALUop     = ADD;
    SC_IN     = 1'b0;
    FlagEn    = 1'b0;

    //          op   a      b      sc    rslt   z     p     sco
    vecs.push_back(mk(ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(SUB, 8'h04, 8'h01, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(SUB, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(LSH, 8'h81, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(LSH, 8'h40, 8'h00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(RSH, 8'h81, 8'h00, 1'b1, 8'h40, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(RSH, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(CMP, 8'h05, 8'h03, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(CMP, 8'h03, 8'h05, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(CMP, 8'h07, 8'h07, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(CMP, 8'hFF, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(AND, 8'h04, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(AND, 8'hFF, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OR,  8'h04, 8'h01, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OR,  8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(XOR, 8'hF0, 8'hFF, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(XOR, 8'hAA, 8'h54, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(SUB, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1));

    // Reset state of the flag register.
    #1;
    check("reset_sc_q", 8'(SC_Q), 8'h00);

    // Combinational table, applied with reset still low to show results
    // do not depend on Reset_n.
    for (int i = 0; i < vecs.size(); i++) begin
      ALUop = vecs[i].op;
      DatA  = vecs[i].a;
      DatB  = vecs[i].b;
      SC_IN = vecs[i].sc_in;
      #1;
      check($sformatf("v%0d_rslt", i),   Rslt,          vecs[i].rslt);
      check($sformatf("v%0d_zero", i),   8'(Zero),      8'(vecs[i].zero));
      check($sformatf("v%0d_par", i),    8'(Par),       8'(vecs[i].par));
      check($sformatf("v%0d_sc_out", i), 8'(SC_OUT),    8'(vecs[i].sc_out));
    end

    // Held in reset across a clock edge with FlagEn high: stays 0.
    ALUop = ADD; DatA = 8'hFF; DatB = 8'h01; FlagEn = 1'b1;
    @(posedge Clk); #1;
    check("held_in_reset", 8'(SC_Q), 8'h00);

    // Release reset mid-cycle; first capture is on the next rising edge.
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    check("release_no_capture", 8'(SC_Q), 8'h00);
    @(posedge Clk); #1;
    check("flagen_load_1", 8'(SC_Q), 8'h01);

    // FlagEn low: hold even though SC_OUT is now 0.
    @(negedge Clk);
    ALUop = SUB; DatA = 8'h04; DatB = 8'h01; FlagEn = 1'b0;
    @(posedge Clk); #1;
    check("flagen_hold", 8'(SC_Q), 8'h01);

    // FlagEn high with SC_OUT=0 loads 0.
    @(negedge Clk);
    FlagEn = 1'b1;
    @(posedge Clk); #1;
    check("flagen_load_0", 8'(SC_Q), 8'h00);

    // Reload 1 via LSH shift-out, then async reset between edges.
    @(negedge Clk);
    ALUop = LSH; DatA = 8'h81; SC_IN = 1'b1;
    @(posedge Clk); #1;
    check("lsh_load_1", 8'(SC_Q), 8'h01);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset", 8'(SC_Q), 8'h00);
    check("rslt_during_reset", Rslt, 8'h03);
    check("sc_out_during_reset", 8'(SC_OUT), 8'h01);
    @(posedge Clk); #1;
    check("reset_hold", 8'(SC_Q), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
